incoming_response_buffer: RTL and testbench
===========================================

# incoming_response_buffer

- Buffers AXI R beats arriving from the downstream slave before they enter `r_ordering_unit`.
- It is the receive-side counterpart of the outgoing response buffer: an 8-entry FIFO with an optional store-and-forward mode.
- In store-and-forward mode, beats are released only once a complete burst (through its `last` beat) is resident.
- The ordering unit therefore never stalls mid-burst waiting on the slave.

## Interface

Parameters:
- ID_WIDTH, 32, R channel ID width
- DATA_WIDTH, 64, R data width
- RESP_WIDTH, 2, RRESP width
- DEPTH, 8, FIFO entries (≥2); PTR_W = $clog2(DEPTH), CNT_W = $clog2(DEPTH+1)
- STORE_AND_FORWARD, 1, 1 = gate output on a complete burst; 0 = plain FIFO

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- r_in  r_if.receiver  bundle  R beats from AXI slave (id, data, resp, last, valid; ready driven here)
- r_out  r_if.sender  bundle  R beats to r_ordering_unit (id, data, resp, last, valid driven here; ready input)
- occupancy  output  CNT_W  beats stored (count_q)
- bursts_stored  output  CNT_W  complete bursts (stored beats with last=1)

## Operation

- Storage: circular array of {id, data, resp, last}; wr_ptr_q, rd_ptr_q wrap DEPTH-1 → 0; count_q 0..DEPTH.
- Storage contents are not reset.
- empty = (count_q == 0); full = (count_q == DEPTH).
- r_in.ready = ~full. A push when full is impossible, even with a same-cycle pop.
- push = r_in.valid & r_in.ready; pop = r_out.valid & r_out.ready.
- Count update:
  - push only: +1.
  - pop only: −1.
  - both: unchanged.
- bursts_q update:
  - +1 on push with r_in.last = 1.
  - −1 on pop whose head has last = 1.
  - Both in the same cycle: unchanged.
- drain_q resolves the full-without-last deadlock:
  - Set when full & (bursts_q == 0).
  - Cleared on a pop whose head last = 1, or when count_q reaches 0.
  - Clear has priority over set.
- r_out.valid:
  - STORE_AND_FORWARD = 0: ~empty.
  - STORE_AND_FORWARD = 1: ~empty & ((bursts_q != 0) | drain_q | full).
- Head data: r_out.{id, data, resp, last} = mem[rd_ptr_q] when r_out.valid. All fields are 0 when r_out.valid = 0.
- AXI stability: once r_out.valid = 1, valid and head fields stay stable until pop. Nothing can lower the gate without a pop, because bursts_q only decrements on pop and full only falls on pop.
- Reset (any time, including mid-burst): pointers, count_q, bursts_q, drain_q → 0. Partially received bursts are discarded.

## Timing

- Reset values: r_in.ready = 1, r_out.valid = 0, r_out fields = 0, occupancy = 0, bursts_stored = 0.
- Latency: a beat pushed on edge N is visible on r_out at cycle N+1 when the gate is open.
- In STORE_AND_FORWARD = 1, the first beat of a burst appears the cycle after its last beat is pushed.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- r_in.ready and r_out.valid are functions of registers only. There is no combinational path from r_out.ready to r_in.ready, or from r_in.valid to r_out.valid.
- Wrap-around: the pointer after DEPTH-1 is 0. There is no special case for a simultaneous wrap of both pointers.

## Test plan

- **Single-beat bursts, SAF = 1:** push id=3/data=0xA5/last=1 with r_out.ready = 1.
  - r_out.valid rises the next cycle with id=3, data=0xA5, last=1.
  - Popped; occupancy returns to 0.
- **4-beat burst, SAF = 1, one beat per cycle:**
  - r_out.valid stays 0 for cycles 1–4; bursts_stored stays 0 until the last beat is pushed.
  - Valid rises at cycle 5; beats drain in order over 4 cycles.
  - bursts_stored goes 1 → 0 on the fourth pop.
- **Full without last, SAF = 1:** push 8 beats with last = 0 and r_out.ready = 0.
  - r_in.ready = 0 and r_out.valid = 1; drain_q = 1.
  - Pop 3 beats, push the 9th beat with last = 1: valid stays 1 throughout, all 9 beats come out in order, drain_q clears on the last pop.
- **Simultaneous push/pop at count = 3, SAF = 0:** occupancy stays 3; output order is preserved across 20 cycles of random ready with pointer wrap.
- **Backpressure stability:** hold r_out.ready = 0 for 5 cycles while valid = 1; head fields and valid must not change.
- **Reset mid-burst:** push 2 beats of a burst, assert rst for 1 cycle.
  - Next cycle: occupancy = 0, bursts_stored = 0, r_out.valid = 0, r_in.ready = 1.
  - A new 1-beat burst passes normally.

Source files
------------

// File: rtl/incoming_response_buffer_if.sv
// R channel bundle: one beat of {id, data, resp, last} with valid/ready handshake.
interface r_if #(
    parameter int ID_WIDTH   = 32,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2
);
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [RESP_WIDTH-1:0] resp;
    logic                  last;
    logic                  valid;
    logic                  ready;

    // Side that accepts beats (drives ready).
    modport receiver (input id, data, resp, last, valid, output ready);
    // Side that offers beats (drives payload and valid).
    modport sender (output id, data, resp, last, valid, input ready);
endinterface

// File: rtl/incoming_response_buffer.sv
// Receive-side R beat FIFO in front of the ordering unit. In store-and-forward
// mode the head is only offered once a whole burst is resident, so the
// consumer never waits on the slave mid-burst.
module incoming_response_buffer #(
    parameter int ID_WIDTH          = 32,
    parameter int DATA_WIDTH        = 64,
    parameter int RESP_WIDTH        = 2,
    parameter int DEPTH             = 8,
    parameter bit STORE_AND_FORWARD = 1'b1,
    localparam int PTR_W            = $clog2(DEPTH),
    localparam int CNT_W            = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    r_if.receiver            r_in,
    r_if.sender              r_out,
    output logic [CNT_W-1:0] occupancy,
    output logic [CNT_W-1:0] bursts_stored
);

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
        logic [RESP_WIDTH-1:0] resp;
        logic                  last;
    } entry_t;

    entry_t mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_next;
    logic [CNT_W-1:0] count_q, count_next;
    logic [CNT_W-1:0] bursts_q, bursts_next;
    logic             drain_q, drain_next;

    logic   full;
    logic   empty;
    logic   out_valid;
    logic   push;
    logic   pop;
    entry_t head;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem[rd_ptr_q];

    // Output gate: plain FIFO, or hold back until a burst is complete. The
    // full / drain terms keep a burst longer than the FIFO from deadlocking.
    generate
        if (STORE_AND_FORWARD) begin : g_saf
            assign out_valid = ~empty & ((bursts_q != '0) | drain_q | full);
        end else begin : g_fifo
            assign out_valid = ~empty;
        end
    endgenerate

    assign push = r_in.valid & ~full;
    assign pop  = out_valid & r_out.ready;

    assign r_in.ready    = ~full;
    assign r_out.valid   = out_valid;
    assign r_out.id      = out_valid ? head.id   : '0;
    assign r_out.data    = out_valid ? head.data : '0;
    assign r_out.resp    = out_valid ? head.resp : '0;
    assign r_out.last    = out_valid ? head.last : 1'b0;
    assign occupancy     = count_q;
    assign bursts_stored = bursts_q;

    // Next-state for pointers, counters and the drain flag.
    always_comb begin
        wr_ptr_next = wr_ptr_q;
        rd_ptr_next = rd_ptr_q;
        count_next  = count_q;
        bursts_next = bursts_q;
        drain_next  = drain_q;

        if (push) begin
            wr_ptr_next = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end

        if (push && !pop) begin
            count_next = count_q + 1'b1;
        end else if (pop && !push) begin
            count_next = count_q - 1'b1;
        end

        if ((push && r_in.last) && !(pop && head.last)) begin
            bursts_next = bursts_q + 1'b1;
        end else if ((pop && head.last) && !(push && r_in.last)) begin
            bursts_next = bursts_q - 1'b1;
        end

        // Clearing wins: the oversize burst has ended or the FIFO emptied.
        if ((pop && head.last) || (count_next == '0)) begin
            drain_next = 1'b0;
        end else if (full && (bursts_q == '0)) begin
            drain_next = 1'b1;
        end
    end

    // Control state register; a reset discards any partially received burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            bursts_q <= '0;
            drain_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_next;
            rd_ptr_q <= rd_ptr_next;
            count_q  <= count_next;
            bursts_q <= bursts_next;
            drain_q  <= drain_next;
        end
    end

    // Beat storage; contents are left as-is across reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= '{id: r_in.id, data: r_in.data, resp: r_in.resp, last: r_in.last};
        end
    end

endmodule

// File: tb/tb_incoming_response_buffer.sv
// Directed bench: a store-and-forward instance driven by a vector table plus
// hand sequences, and a plain-FIFO instance for the push/pop-at-once case.
module tb_incoming_response_buffer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    r_if saf_in ();
    r_if saf_out ();
    r_if ff_in ();
    r_if ff_out ();

    logic [3:0] saf_occ, saf_bur, ff_occ, ff_bur;

    incoming_response_buffer #(.STORE_AND_FORWARD(1'b1)) u_saf (
        .clk           (clk),
        .rst           (rst),
        .r_in          (saf_in),
        .r_out         (saf_out),
        .occupancy     (saf_occ),
        .bursts_stored (saf_bur)
    );

    incoming_response_buffer #(.STORE_AND_FORWARD(1'b0)) u_ff (
        .clk           (clk),
        .rst           (rst),
        .r_in          (ff_in),
        .r_out         (ff_out),
        .occupancy     (ff_occ),
        .bursts_stored (ff_bur)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic [7:0] data;
        logic       il;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_id;
        logic [7:0] e_data;
        logic       e_last;
        int         e_occ;
        int         e_bur;
    } vec_t;

    function automatic vec_t mk(logic iv, logic [7:0] id, logic [7:0] data, logic il, logic ordy,
                                logic e_ir, logic e_ov, logic [7:0] e_id, logic [7:0] e_data,
                                logic e_last, int e_occ, int e_bur);
        vec_t v;
        v.iv = iv; v.id = id; v.data = data; v.il = il; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_id = e_id; v.e_data = e_data;
        v.e_last = e_last; v.e_occ = e_occ; v.e_bur = e_bur;
        return v;
    endfunction

    task automatic drive_saf(input logic iv, input logic [7:0] id, input logic [7:0] data,
                             input logic il, input logic ordy);
        saf_in.valid  = iv;
        saf_in.id     = 32'(id);
        saf_in.data   = 64'(data);
        saf_in.resp   = 2'b00;
        saf_in.last   = il;
        saf_out.ready = ordy;
    endtask

    // Compare the SAF instance's head against an expected beat.
    task automatic chk_head(input string nm, input logic ov, input logic [7:0] id,
                            input logic [7:0] data, input logic last);
        chk({nm, ".valid"}, 64'(saf_out.valid), 64'(ov));
        chk({nm, ".id"},    64'(saf_out.id),    64'(id));
        chk({nm, ".data"},  saf_out.data,       64'(data));
        chk({nm, ".last"},  64'(saf_out.last),  64'(last));
    endtask

    vec_t tbl [12];
    int   q [$];
    int   nxt;
    logic r;

    initial begin
        drive_saf(1'b0, 8'h0, 8'h0, 1'b0, 1'b0);
        ff_in.valid = 1'b0; ff_in.id = '0; ff_in.data = '0; ff_in.resp = '0; ff_in.last = 1'b0;
        ff_out.ready = 1'b0;

        // Single-beat burst, then a 4-beat burst streamed one beat per cycle.
        tbl[0]  = mk(1, 8'h03, 8'hA5, 1, 1,  1, 0, 8'h00, 8'h00, 0, 0, 0);
        tbl[1]  = mk(0, 8'h00, 8'h00, 0, 1,  1, 1, 8'h03, 8'hA5, 1, 1, 1);
        tbl[2]  = mk(0, 8'h00, 8'h00, 0, 1,  1, 0, 8'h00, 8'h00, 0, 0, 0);
        tbl[3]  = mk(1, 8'h05, 8'h10, 0, 1,  1, 0, 8'h00, 8'h00, 0, 0, 0);
        tbl[4]  = mk(1, 8'h05, 8'h11, 0, 1,  1, 0, 8'h00, 8'h00, 0, 1, 0);
        tbl[5]  = mk(1, 8'h05, 8'h12, 0, 1,  1, 0, 8'h00, 8'h00, 0, 2, 0);
        tbl[6]  = mk(1, 8'h05, 8'h13, 1, 1,  1, 0, 8'h00, 8'h00, 0, 3, 0);
        tbl[7]  = mk(0, 8'h00, 8'h00, 0, 1,  1, 1, 8'h05, 8'h10, 0, 4, 1);
        tbl[8]  = mk(0, 8'h00, 8'h00, 0, 1,  1, 1, 8'h05, 8'h11, 0, 3, 1);
        tbl[9]  = mk(0, 8'h00, 8'h00, 0, 1,  1, 1, 8'h05, 8'h12, 0, 2, 1);
        tbl[10] = mk(0, 8'h00, 8'h00, 0, 1,  1, 1, 8'h05, 8'h13, 1, 1, 1);
        tbl[11] = mk(0, 8'h00, 8'h00, 0, 0,  1, 0, 8'h00, 8'h00, 0, 0, 0);

        // Reset state on both instances.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.saf.in_ready", 64'(saf_in.ready), 64'd1);
        chk_head("rst.saf", 1'b0, 8'h0, 8'h0, 1'b0);
        chk("rst.saf.occ", 64'(saf_occ), 64'd0);
        chk("rst.saf.bursts", 64'(saf_bur), 64'd0);
        chk("rst.ff.in_ready", 64'(ff_in.ready), 64'd1);
        chk("rst.ff.valid", 64'(ff_out.valid), 64'd0);

        // Table: drive at the falling edge, check outputs before the next rising edge.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive_saf(tbl[i].iv, tbl[i].id, tbl[i].data, tbl[i].il, tbl[i].ordy);
            #1;
            $display("vec %0d: valid=%0b id=%0h data=%0h last=%0b occ=%0d bursts=%0d",
                     i, saf_out.valid, saf_out.id, saf_out.data, saf_out.last, saf_occ, saf_bur);
            chk($sformatf("vec%0d.in_ready", i), 64'(saf_in.ready), 64'(tbl[i].e_ir));
            chk_head($sformatf("vec%0d", i), tbl[i].e_ov, tbl[i].e_id, tbl[i].e_data, tbl[i].e_last);
            chk($sformatf("vec%0d.occ", i), 64'(saf_occ), 64'(tbl[i].e_occ));
            chk($sformatf("vec%0d.bursts", i), 64'(saf_bur), 64'(tbl[i].e_bur));
        end

        // Full without last: 8 beats, no consumer.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive_saf(1'b1, 8'h07, 8'(8'h20 + i), 1'b0, 1'b0);
        end
        @(negedge clk);
        drive_saf(1'b0, 8'h0, 8'h0, 1'b0, 1'b0);
        #1;
        $display("full: in_ready=%0b valid=%0b occ=%0d", saf_in.ready, saf_out.valid, saf_occ);
        chk("full.in_ready", 64'(saf_in.ready), 64'd0);
        chk_head("full.head", 1'b1, 8'h07, 8'h20, 1'b0);
        chk("full.occ", 64'(saf_occ), 64'd8);
        @(negedge clk);
        #1;
        chk("full.drain_set", 64'(u_saf.drain_q), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive_saf(1'b0, 8'h0, 8'h0, 1'b0, 1'b1);
            #1;
            $display("drain pop %0d: data=%0h", k, saf_out.data);
            chk_head($sformatf("drain.pop%0d", k), 1'b1, 8'h07, 8'(8'h20 + k), 1'b0);
        end
        @(negedge clk);
        drive_saf(1'b1, 8'h07, 8'h28, 1'b1, 1'b0);
        #1;
        chk_head("drain.push9", 1'b1, 8'h07, 8'h23, 1'b0);
        for (int k = 3; k < 9; k++) begin
            @(negedge clk);
            drive_saf(1'b0, 8'h0, 8'h0, 1'b0, 1'b1);
            #1;
            $display("drain pop %0d: data=%0h last=%0b", k, saf_out.data, saf_out.last);
            chk_head($sformatf("drain.pop%0d", k), 1'b1, 8'h07, 8'(8'h20 + k), (k == 8));
            chk($sformatf("drain.flag%0d", k), 64'(u_saf.drain_q), 64'd1);
        end
        @(negedge clk);
        drive_saf(1'b0, 8'h0, 8'h0, 1'b0, 1'b0);
        #1;
        chk("drain.cleared", 64'(u_saf.drain_q), 64'd0);
        chk("drain.occ", 64'(saf_occ), 64'd0);
        chk("drain.valid", 64'(saf_out.valid), 64'd0);

        // Backpressure: head must hold for 5 stalled cycles.
        @(negedge clk);
        drive_saf(1'b1, 8'h09, 8'h5C, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive_saf(1'b0, 8'h0, 8'h0, 1'b0, 1'b0);
            #1;
            $display("stall %0d: valid=%0b data=%0h", k, saf_out.valid, saf_out.data);
            chk_head($sformatf("stall%0d", k), 1'b1, 8'h09, 8'h5C, 1'b1);
        end
        @(negedge clk);
        drive_saf(1'b0, 8'h0, 8'h0, 1'b0, 1'b1);
        @(negedge clk);
        drive_saf(1'b0, 8'h0, 8'h0, 1'b0, 1'b0);
        #1;
        chk("stall.occ_after", 64'(saf_occ), 64'd0);

        // Reset mid-burst discards the partial burst.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive_saf(1'b1, 8'h0B, 8'(8'h60 + k), 1'b0, 1'b0);
        end
        @(negedge clk);
        drive_saf(1'b0, 8'h0, 8'h0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        $display("midrst: occ=%0d bursts=%0d valid=%0b", saf_occ, saf_bur, saf_out.valid);
        chk("midrst.occ", 64'(saf_occ), 64'd0);
        chk("midrst.bursts", 64'(saf_bur), 64'd0);
        chk("midrst.valid", 64'(saf_out.valid), 64'd0);
        chk("midrst.in_ready", 64'(saf_in.ready), 64'd1);
        @(negedge clk);
        drive_saf(1'b1, 8'h0C, 8'h77, 1'b1, 1'b1);
        @(negedge clk);
        drive_saf(1'b0, 8'h0, 8'h0, 1'b0, 1'b1);
        #1;
        chk_head("midrst.after", 1'b1, 8'h0C, 8'h77, 1'b1);
        @(negedge clk);
        drive_saf(1'b0, 8'h0, 8'h0, 1'b0, 1'b0);
        #1;
        chk("midrst.occ_after", 64'(saf_occ), 64'd0);

        // Plain FIFO: prefill 3, then push exactly when popping so count holds at 3.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ff_in.valid = 1'b1; ff_in.data = 64'(8'h40 + k); ff_out.ready = 1'b0;
            q.push_back(8'h40 + k);
        end
        nxt = 8'h43;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            r = 1'($urandom_range(0, 1));
            ff_in.valid = r; ff_in.data = 64'(nxt); ff_out.ready = r;
            #1;
            $display("ff cyc %0d: ready=%0b head=%0h occ=%0d", k, r, ff_out.data, ff_occ);
            chk($sformatf("ff%0d.occ", k), 64'(ff_occ), 64'd3);
            chk($sformatf("ff%0d.data", k), ff_out.data, 64'(q[0]));
            if (r) begin
                void'(q.pop_front());
                q.push_back(nxt);
                nxt++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ff_in.valid = 1'b0; ff_out.ready = 1'b1;
            #1;
            chk($sformatf("ffdrain%0d.data", k), ff_out.data, 64'(q[0]));
            void'(q.pop_front());
        end
        @(negedge clk);
        ff_out.ready = 1'b0;
        #1;
        chk("ff.empty", 64'(ff_occ), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
